vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/scroll_counter.sv | 33 +++
 rtl/vga_timing_gen.sv | 94 +++++++++
 tb/tb_vga_timing_gen.sv | 138 +++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (1280x1024 @ 60 Hz defaults) and decode helpers
// used by the timing generator and the draw stages.
package vga_timing_pkg;

    localparam int unsigned COUNT_W = 11;
    localparam int unsigned SHIFT_W = 6;
    localparam int unsigned SPEED_W = 3;

    localparam int unsigned H_VIS_DEFAULT  = 1280;
    localparam int unsigned H_FP_DEFAULT   = 48;
    localparam int unsigned H_SYNC_DEFAULT = 112;
    localparam int unsigned H_TOT_DEFAULT  = 1688;

    localparam int unsigned V_VIS_DEFAULT  = 1024;
    localparam int unsigned V_FP_DEFAULT   = 1;
    localparam int unsigned V_SYNC_DEFAULT = 3;
    localparam int unsigned V_TOT_DEFAULT  = 1066;

    typedef logic [COUNT_W-1:0] count_t;

    typedef struct packed {
        logic hsync;
        logic hblnk;
        logic vsync;
        logic vblnk;
    } sync_t;

    // Half-open window test: lo <= x < hi.
    function automatic logic in_window(input count_t x, input count_t lo, input count_t hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/scroll_counter.sv
// Frame-rate scroll accumulator: adds speed to a 6-bit offset on each frame tick.
module scroll_counter
    import vga_timing_pkg::*;
(
    input  logic               pclk,
    input  logic               rst,
    input  logic               tick,
    input  logic               en,
    input  logic [SPEED_W-1:0] speed,
    output logic [SHIFT_W-1:0] shift
);

    logic [SHIFT_W-1:0] shift_q, shift_d;

    // Wraps modulo 64 by construction of the 6-bit adder.
    always_comb begin
        shift_d = shift_q;
        if (tick && en) begin
            shift_d = shift_q + SHIFT_W'(speed);
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign shift = shift_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: registered h/v counters with zero-skew sync/blank and a
// per-frame scroll offset.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VIS  = H_VIS_DEFAULT,
    parameter int unsigned H_FP   = H_FP_DEFAULT,
    parameter int unsigned H_SYNC = H_SYNC_DEFAULT,
    parameter int unsigned H_TOT  = H_TOT_DEFAULT,
    parameter int unsigned V_VIS  = V_VIS_DEFAULT,
    parameter int unsigned V_FP   = V_FP_DEFAULT,
    parameter int unsigned V_SYNC = V_SYNC_DEFAULT,
    parameter int unsigned V_TOT  = V_TOT_DEFAULT
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               scroll_en,
    input  logic [SPEED_W-1:0] speed,
    output logic [COUNT_W-1:0] vcount_out,
    output logic               vsync_out,
    output logic               vblnk_out,
    output logic [COUNT_W-1:0] hcount_out,
    output logic               hsync_out,
    output logic               hblnk_out,
    output logic               frame_tick,
    output logic [SHIFT_W-1:0] shift
);

    localparam count_t H_LAST     = COUNT_W'(H_TOT - 1);
    localparam count_t V_LAST     = COUNT_W'(V_TOT - 1);
    localparam count_t H_BLNK_BEG = COUNT_W'(H_VIS);
    localparam count_t H_SYNC_BEG = COUNT_W'(H_VIS + H_FP);
    localparam count_t H_SYNC_END = COUNT_W'(H_VIS + H_FP + H_SYNC);
    localparam count_t V_BLNK_BEG = COUNT_W'(V_VIS);
    localparam count_t V_SYNC_BEG = COUNT_W'(V_VIS + V_FP);
    localparam count_t V_SYNC_END = COUNT_W'(V_VIS + V_FP + V_SYNC);

    count_t hcount_q, hcount_d;
    count_t vcount_q, vcount_d;
    sync_t  sync_q, sync_d;
    logic   tick_q;
    logic   h_wrap, v_wrap, frame_start;

    always_comb begin
        h_wrap      = (hcount_q == H_LAST);
        v_wrap      = (vcount_q == V_LAST);
        frame_start = h_wrap && v_wrap;

        hcount_d = h_wrap ? '0 : hcount_q + COUNT_W'(1);
        vcount_d = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + COUNT_W'(1);
        end

        // Decode from next-state counts so registered flags line up with the counters.
        sync_d       = '0;
        sync_d.hblnk = (hcount_d >= H_BLNK_BEG);
        sync_d.hsync = in_window(hcount_d, H_SYNC_BEG, H_SYNC_END);
        sync_d.vblnk = (vcount_d >= V_BLNK_BEG);
        sync_d.vsync = in_window(vcount_d, V_SYNC_BEG, V_SYNC_END);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            sync_q   <= '0;
            tick_q   <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            sync_q   <= sync_d;
            tick_q   <= frame_start;
        end
    end

    scroll_counter u_scroll_counter (
        .pclk  (pclk),
        .rst   (rst),
        .tick  (frame_start),
        .en    (scroll_en),
        .speed (speed),
        .shift (shift)
    );

    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign hsync_out  = sync_q.hsync;
    assign hblnk_out  = sync_q.hblnk;
    assign vsync_out  = sync_q.vsync;
    assign vblnk_out  = sync_q.vblnk;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster, checked against an
// arithmetic model derived from the edge count since reset release.
module tb_vga_timing_gen;

    localparam int unsigned HV = 20, HF = 3, HS = 5, HT = 32;
    localparam int unsigned VV = 12, VF = 1, VS = 2, VT = 18;
    localparam int unsigned FRAME = HT * VT;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        scroll_en = 1'b0;
    logic [2:0]  speed = 3'd0;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out, frame_tick;
    logic [5:0]  shift;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n = 0;
    int unsigned exp_shift = 0;
    int unsigned ticks_seen = 0;
    int unsigned ticks_exp = 0;

    vga_timing_gen #(
        .H_VIS  (HV),
        .H_FP   (HF),
        .H_SYNC (HS),
        .H_TOT  (HT),
        .V_VIS  (VV),
        .V_FP   (VF),
        .V_SYNC (VS),
        .V_TOT  (VT)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .scroll_en  (scroll_en),
        .speed      (speed),
        .vcount_out (vcount_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .hcount_out (hcount_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .frame_tick (frame_tick),
        .shift      (shift)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int unsigned h, v;
        h = n % HT;
        v = (n / HT) % VT;
        check_eq("hcount", hcount_out, h);
        check_eq("vcount", vcount_out, v);
        check_eq("hblnk", hblnk_out, (h >= HV) ? 1 : 0);
        check_eq("hsync", hsync_out, (h >= HV + HF && h < HV + HF + HS) ? 1 : 0);
        check_eq("vblnk", vblnk_out, (v >= VV) ? 1 : 0);
        check_eq("vsync", vsync_out, (v >= VV + VF && v < VV + VF + VS) ? 1 : 0);
        check_eq("frame_tick", frame_tick, (n != 0 && n % FRAME == 0) ? 1 : 0);
        check_eq("shift", shift, exp_shift);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_hcount"}, hcount_out, 0);
        check_eq({tag, "_vcount"}, vcount_out, 0);
        check_eq({tag, "_hsync"}, hsync_out, 0);
        check_eq({tag, "_vsync"}, vsync_out, 0);
        check_eq({tag, "_hblnk"}, hblnk_out, 0);
        check_eq({tag, "_vblnk"}, vblnk_out, 0);
        check_eq({tag, "_tick"}, frame_tick, 0);
        check_eq({tag, "_shift"}, shift, 0);
    endtask

    // Inputs are applied #1 after an edge, so the model uses the values held across it.
    task automatic step();
        @(posedge pclk);
        #1;
        n++;
        if (n % FRAME == 0) begin
            ticks_exp++;
            if (scroll_en) exp_shift = (exp_shift + speed) % 64;
        end
        if (frame_tick) ticks_seen++;
        check_model();
        scroll_en = ($urandom_range(0, 3) != 0);
        speed     = 3'($urandom);
    endtask

    task automatic release_reset();
        @(posedge pclk);
        #1;
        rst = 1'b1;
        n = 0;
        exp_shift = 0;
        check_model();
    endtask

    initial begin
        int unsigned found;
        repeat (3) @(posedge pclk);
        #1;
        check_zero("reset");
        release_reset();

        for (int i = 0; i < FRAME * 20 + 37; i++) step();

        // Seek a point with both syncs active, then reset asynchronously.
        found = 0;
        for (int i = 0; i < FRAME + 1 && found == 0; i++) begin
            step();
            if (hsync_out && vsync_out) found = 1;
        end
        check_eq("sync_seek", found, 1);
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (2) @(posedge pclk);
        #1;
        check_zero("held_rst");
        release_reset();

        for (int i = 0; i < FRAME * 15 + 5; i++) step();

        check_eq("tick_count", ticks_seen, ticks_exp);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
